// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper controller: FSM states, drive modes,
// half-step coil table and the per-tick index advance.
package stepper_pkg;

  typedef enum logic [1:0] {IDLE, RUN_CONT, MOVE} state_t;

  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;

  // Entry 0 is the least significant nibble: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001
  localparam logic [7:0][3:0] HALF_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                          4'b0110, 4'b0100, 4'b1100, 4'b1000};

  // Wave sits on even indices, full on odd; a wrong-parity index takes a single realign step.
  function automatic logic [2:0] step_amt(input logic [1:0] m, input logic odd);
    case (m)
      MODE_WAVE: step_amt = odd ? 3'd1 : 3'd2;
      MODE_FULL: step_amt = odd ? 3'd2 : 3'd1;
      default:   step_amt = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate divider: one-cycle tick every max(div_val,1) cycles while enabled.
module step_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lim;

  // >= so a divider shortened mid-count fires at once instead of wrapping around
  assign lim  = (div_val == '0) ? '0 : div_val - DIV_W'(1);
  assign tick = en && (cnt >= lim);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clr || !en || tick) cnt <= '0;
    else                         cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/stepper_ctrl.sv
// Unipolar stepper controller: continuous run or counted moves, wave/full/half drive,
// programmable step rate, coil hold and signed position tracking.
module stepper_ctrl
  import stepper_pkg::*;
#(
  parameter int DIV_W = 24,
  parameter int CNT_W = 16,
  parameter int POS_W = 16
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             DIR,
  input  logic             RUN,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             hold,
  output logic [3:0]       JC,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  state_t           state, state_n;
  logic [2:0]       idx, idx_n, amt;
  logic [CNT_W-1:0] rem, rem_n;
  logic [POS_W-1:0] pos_n;
  logic [3:0]       jc_n;
  logic             tick, clr, done_set, mv_end, run_blk;

  assign clr  = (state == RUN_CONT) && start && (target != '0);
  assign busy = (state != IDLE);

  step_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .CLK(CLK), .reset_n(reset_n), .en(busy), .clr(clr), .div_val(div_val), .tick(tick)
  );

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    done_set = 1'b0;
    mv_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (target != '0) begin
            state_n = MOVE;
            rem_n   = target;
          end else begin
            done_set = 1'b1;
          end
        end else if (RUN && !run_blk) begin
          state_n = RUN_CONT;
        end
      end
      RUN_CONT: begin
        if (start && target != '0) begin
          state_n = MOVE;
          rem_n   = target;
        end else if (!RUN) begin
          state_n = IDLE;
        end
      end
      MOVE: begin
        if (tick) begin
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_n  = IDLE;
            done_set = 1'b1;
            mv_end   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    amt   = step_amt(mode, idx[0]);
    idx_n = idx;
    pos_n = position;
    if (tick) begin
      idx_n = DIR ? idx + amt : idx - amt;
      pos_n = DIR ? position + POS_W'(1) : position - POS_W'(1);
    end
    jc_n = (state_n != IDLE || hold) ? HALF_TBL[idx_n] : 4'b0000;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      rem      <= '0;
      position <= '0;
      JC       <= '0;
      done     <= 1'b0;
      run_blk  <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      rem      <= rem_n;
      position <= pos_n;
      JC       <= jc_n;
      done     <= done_set;
      // a held RUN must be released and re-asserted before continuous stepping resumes
      if (mv_end && RUN) run_blk <= 1'b1;
      else if (!RUN)     run_blk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Directed bench for stepper_ctrl: table-driven continuous run plus hand-written move sequences.
module tb_stepper_ctrl;

  logic        CLK, reset_n, DIR, RUN, start, hold, done, busy;
  logic [15:0] target, position;
  logic [1:0]  mode;
  logic [23:0] div_val;
  logic [3:0]  JC;

  int n_cmp = 0;
  int n_bad = 0;

  stepper_ctrl dut (
    .CLK(CLK), .reset_n(reset_n), .DIR(DIR), .RUN(RUN), .start(start), .target(target),
    .mode(mode), .div_val(div_val), .hold(hold), .JC(JC), .busy(busy), .done(done),
    .position(position)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       run;
    int         ncyc;
    logic [3:0] jc;
    int         pos;
    logic       busy;
  } vec_t;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int spos();
    return int'($signed(position));
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    RUN = 0; start = 0; DIR = 1; hold = 0; mode = 2; div_val = 4; target = 0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  vec_t vt[7];
  logic [3:0] fj[5];
  logic       fd[5];
  logic       fb[5];
  int         dcnt;

  initial begin
    vt[0] = '{1'b1, 1,  4'b1000, 0,  1'b1};
    vt[1] = '{1'b1, 3,  4'b1000, 0,  1'b1};
    vt[2] = '{1'b1, 1,  4'b1100, 1,  1'b1};
    vt[3] = '{1'b1, 4,  4'b0100, 2,  1'b1};
    vt[4] = '{1'b1, 4,  4'b0110, 3,  1'b1};
    vt[5] = '{1'b1, 28, 4'b0100, 10, 1'b1};
    vt[6] = '{1'b0, 1,  4'b0000, 10, 1'b0};
    fj = '{4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b0000};
    fd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // reset state
    do_reset();
    check("rst_jc", int'(JC), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pos", spos(), 0);

    // half mode continuous run, div 4
    for (int i = 0; i < 7; i++) begin
      RUN = vt[i].run;
      cyc(vt[i].ncyc);
      check($sformatf("run%0d_jc", i), int'(JC), int'(vt[i].jc));
      check($sformatf("run%0d_pos", i), spos(), vt[i].pos);
      check($sformatf("run%0d_busy", i), int'(busy), int'(vt[i].busy));
    end

    // full mode counted move, reverse, realign first
    do_reset();
    mode = 1; div_val = 1; DIR = 0; target = 5; start = 1;
    cyc(1);
    start = 0;
    check("full_entry_jc", int'(JC), 4'b1000);
    check("full_entry_busy", int'(busy), 1);
    dcnt = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      if (done) dcnt++;
      check($sformatf("full%0d_jc", k), int'(JC), int'(fj[k]));
      check($sformatf("full%0d_done", k), int'(done), int'(fd[k]));
      check($sformatf("full%0d_busy", k), int'(busy), int'(fb[k]));
    end
    cyc(1);
    if (done) dcnt++;
    check("full_done_cnt", dcnt, 1);
    check("full_pos", spos(), -5);

    // wave mode, div 0 treated as 1, hold keeps last pattern
    do_reset();
    mode = 0; div_val = 0; DIR = 1; hold = 1; target = 3; start = 1;
    cyc(1);
    start = 0;
    check("wave_e_jc", int'(JC), 4'b1000);
    cyc(1); check("wave1_jc", int'(JC), 4'b0100);
    cyc(1); check("wave2_jc", int'(JC), 4'b0010);
    cyc(1); check("wave3_jc", int'(JC), 4'b0001);
    check("wave_done", int'(done), 1);
    check("wave_busy", int'(busy), 0);
    cyc(2);
    check("wave_hold_jc", int'(JC), 4'b0001);
    check("wave_done_lo", int'(done), 0);
    check("wave_pos", spos(), 3);

    // start with target 0: done pulse only
    target = 0; start = 1;
    cyc(1);
    start = 0;
    check("t0_done", int'(done), 1);
    check("t0_jc", int'(JC), 4'b0001);
    check("t0_pos", spos(), 3);
    check("t0_busy", int'(busy), 0);
    cyc(1);
    check("t0_done_lo", int'(done), 0);

    // start while running: move overrides, RUN must re-rise afterwards
    do_reset();
    mode = 2; div_val = 2; DIR = 1; RUN = 1;
    cyc(3);
    check("rm_pos1", spos(), 1);
    target = 2; start = 1;
    cyc(1);
    start = 0;
    check("rm_busy", int'(busy), 1);
    cyc(4);
    check("rm_pos", spos(), 3);
    check("rm_done", int'(done), 1);
    check("rm_idle", int'(busy), 0);
    cyc(4);
    check("rm_stay_idle", int'(busy), 0);
    check("rm_stay_pos", spos(), 3);
    RUN = 0; cyc(1);
    RUN = 1; cyc(1);
    check("rm_rerun", int'(busy), 1);

    // shrink divider mid-count
    do_reset();
    mode = 2; div_val = 10; DIR = 1; RUN = 1;
    cyc(7);
    check("dv_pre", spos(), 0);
    div_val = 3;
    cyc(1); check("dv_imm", spos(), 1);
    cyc(2); check("dv_wait", spos(), 1);
    cyc(1); check("dv_next", spos(), 2);
    cyc(3); check("dv_next2", spos(), 3);

    // reset mid-move: immediate abort, no done
    do_reset();
    div_val = 2; target = 100; start = 1;
    cyc(1);
    start = 0;
    cyc(5);
    check("ab_busy_pre", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("ab_jc", int'(JC), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_pos", spos(), 0);
    check("ab_done", int'(done), 0);
    cyc(1);
    reset_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      if (done) dcnt++;
    end
    check("ab_no_done", dcnt, 0);
    check("ab_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
